level_sequencer: RTL and testbench
==================================

Name: level_sequencer

Overview:
- Game-level controller that sequences the loot map generator: it issues the level-start pulse and drives the level number.
- Waits out map generation, then runs the level: consumes caught-loot reports, accumulates score, counts down the level timer and decides clear, timeout or win.
- Sits between the key/frame logic and the loot matrix; its outputs also feed the score/time display.

Parameters:
- NUM_LEVELS, 4, last level index; levels run 1..NUM_LEVELS (max 7).
- FRAMES_PER_SEC, 60, start_of_frame pulses per timer second.
- LEVEL_TIME_SEC, 60, initial time_left per level (max 255).
- GEN_WAIT_CYCLES, 512, clk cycles held in GEN_ST after start_level; must exceed worst-case map generation time.
- WIN_HOLD_FRAMES, 120, frames shown in CLEAR_ST before the next level.
- GOLD_VALUE, 10, score per gold.
- ROCK_VALUE, 1, score per rock.
- TIME_BONUS, 5, score per leftover second (optional feature only).

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset
- start_game  in  1  one-cycle pulse from the key debouncer
- start_of_frame  in  1  one-cycle pulse per video frame
- caught_loot_type  in  3  type of loot caught this cycle; 0 = none, 1 = gold, 2 = rock; valid only on the cycle it is nonzero
- total_amount  in  8  loot count for the current level_num (combinational from the loot matrix)
- start_level  out  1  one-cycle pulse to the loot matrix
- level_num  out  3  current level
- score  out  16  accumulated score
- time_left  out  8  seconds remaining
- level_active  out  1  high in PLAY_ST only (gates claw/collision logic)
- game_over  out  1  high in OVER_ST
- game_won  out  1  high in WON_ST

Behaviour:
- Clock and reset: one clock, clk. resetN is synchronous and active-low, sampled on posedge clk.
- Reset values: state = IDLE_ST, start_level = 0, level_num = 0, score = 0, time_left = 0, level_active = 0, game_over = 0, game_won = 0, all internal counters = 0.
- Reset mid-operation: takes effect on the next edge regardless of state.
- States: IDLE_ST, START_ST, GEN_ST, PLAY_ST, CLEAR_ST, OVER_ST, WON_ST.
- IDLE_ST: on start_game, set level_num = 1 and score = 0, then go to START_ST.
- START_ST (1 cycle):
  - start_level = 1 for exactly this cycle.
  - level_num is already stable and is held for the whole level.
  - Load time_left = LEVEL_TIME_SEC; clear caught_cnt, frame_cnt and wait_cnt; go to GEN_ST.
- GEN_ST:
  - wait_cnt increments each cycle.
  - When wait_cnt == GEN_WAIT_CYCLES-1, latch target = total_amount and go to PLAY_ST.
  - caught_loot_type is ignored in this state.
- PLAY_ST, caught loot:
  - Nonzero caught_loot_type: caught_cnt += 1 and score += value (GOLD_VALUE or ROCK_VALUE).
  - Other nonzero types add 0 but still count.
  - score saturates at 16'hFFFF.
- PLAY_ST, timer:
  - On start_of_frame, frame_cnt increments.
  - At FRAMES_PER_SEC-1, frame_cnt wraps to 0 and time_left decrements, saturating at 0.
- PLAY_ST, exits:
  - Clear: caught_cnt (after this cycle's update) == target goes to CLEAR_ST. target == 0 clears on the first PLAY cycle.
  - Timeout: time_left == 0 with clear not reached goes to OVER_ST.
  - If clear and timeout occur on the same cycle, clear wins.
- CLEAR_ST:
  - Counts WIN_HOLD_FRAMES start_of_frame pulses.
  - Then, if level_num == NUM_LEVELS, go to WON_ST; else level_num += 1 and go to START_ST.
- OVER_ST / WON_ST: hold the outputs. start_game sets level_num = 1 and score = 0, then goes to START_ST.
- start_game in any other state is ignored.
- Output latency: registered outputs, valid one cycle after the state transition.
- level_num is never 0 outside IDLE_ST.

Optional Feature:
- Macro: LEVEL_SEQ_TIME_BONUS_EN.
- Defined: on entry to CLEAR_ST, score += time_left*TIME_BONUS (saturating), applied in the single transition cycle.
- Not defined: score changes only on caught loot.

Decomposition:
- Package game_pkg:
  - loot type constants LOOT_NONE = 0, LOOT_GOLD = 1, LOOT_ROCK = 2 (3-bit);
  - seq_state_t enum;
  - SCORE_W = 16;
  - sat_add16 function.
- Sub-module sec_countdown: frame_cnt plus time_left; inputs load, enable, start_of_frame; output zero flag.

Test Plan:
- Reset then start_game -> start_level high for exactly 1 cycle, level_num = 1, time_left = 60; level_active rises 512 cycles after the pulse.
- total_amount = 3; caught types 1, 2, 1 in PLAY -> score = 21, CLEAR_ST entered the cycle after the third catch, level_num = 2 after 120 frames, second start_level pulse.
- No catches for 3600 frames -> time_left reaches 0, game_over = 1, level_active = 0; start_game then gives level_num = 1, score = 0.
- Last catch on the same cycle time_left hits 0 -> CLEAR_ST, not OVER_ST.
- Clear level 4 with NUM_LEVELS = 4 -> game_won = 1, no further start_level; catches and start_of_frame during GEN_ST change nothing.
- Score preloaded near 16'hFFF9 and gold caught -> score = 16'hFFFF; with LEVEL_SEQ_TIME_BONUS_EN and a clear at time_left = 12 -> +60.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the game sequencing logic: loot codes,
// sequencer state encoding and a saturating 16-bit score adder.
package game_pkg;

  localparam int SCORE_W = 16;

  localparam logic [2:0] LOOT_NONE = 3'd0;
  localparam logic [2:0] LOOT_GOLD = 3'd1;
  localparam logic [2:0] LOOT_ROCK = 3'd2;

  typedef enum logic [2:0] {
    IDLE_ST,
    START_ST,
    GEN_ST,
    PLAY_ST,
    CLEAR_ST,
    OVER_ST,
    WON_ST
  } seq_state_t;

  function automatic logic [SCORE_W-1:0] sat_add16(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// Level timer: divides start_of_frame pulses into seconds and counts time_left
// down to zero. zero_o looks at the post-update value so the caller sees a
// timeout on the same cycle the last second expires.
module sec_countdown #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int LEVEL_TIME_SEC = 60
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       load_i,
  input  logic       enable_i,
  input  logic       start_of_frame_i,
  output logic [7:0] time_left_o,
  output logic [7:0] time_left_next_o,
  output logic       zero_o
);

  localparam int FRAME_W = $clog2(FRAMES_PER_SEC + 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);

  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]         time_left_q, time_left_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    time_left_d = time_left_q;
    if (load_i) begin
      frame_cnt_d = '0;
      time_left_d = 8'(LEVEL_TIME_SEC);
    end else if (enable_i && start_of_frame_i) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        if (time_left_q != 8'd0) time_left_d = time_left_q - 8'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      frame_cnt_q <= '0;
      time_left_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      time_left_q <= time_left_d;
    end
  end

  assign time_left_o      = time_left_q;
  assign time_left_next_o = time_left_d;
  assign zero_o           = (time_left_d == 8'd0);

endmodule

// File: rtl/level_sequencer.sv
// Game-level controller: pulses start_level, waits out map generation, runs the
// level timer and score, and decides clear/timeout/win. LEVEL_SEQ_TIME_BONUS_EN
// adds a leftover-seconds bonus to the score on each level clear.
module level_sequencer
  import game_pkg::*;
#(
  parameter int NUM_LEVELS      = 4,
  parameter int FRAMES_PER_SEC  = 60,
  parameter int LEVEL_TIME_SEC  = 60,
  parameter int GEN_WAIT_CYCLES = 512,
  parameter int WIN_HOLD_FRAMES = 120,
  parameter int GOLD_VALUE      = 10,
  parameter int ROCK_VALUE      = 1,
  parameter int TIME_BONUS      = 5
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start_game,
  input  logic               start_of_frame,
  input  logic [2:0]         caught_loot_type,
  input  logic [7:0]         total_amount,
  output logic               start_level,
  output logic [2:0]         level_num,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         time_left,
  output logic               level_active,
  output logic               game_over,
  output logic               game_won
);

`ifdef LEVEL_SEQ_TIME_BONUS_EN
  localparam int BONUS_PER_SEC = TIME_BONUS;
`else
  localparam int BONUS_PER_SEC = 0;
`endif

  localparam logic [15:0] GEN_LAST  = 16'(GEN_WAIT_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(WIN_HOLD_FRAMES - 1);

  seq_state_t         state_q;
  logic               start_level_q, level_active_q, game_over_q, game_won_q;
  logic [2:0]         level_num_q;
  logic [SCORE_W-1:0] score_q;
  logic [7:0]         caught_cnt_q, target_q;
  logic [15:0]        wait_cnt_q;

  logic [SCORE_W-1:0] loot_val, bonus_val, score_play_d, score_clear_d;
  logic [7:0]         caught_cnt_d;
  logic [7:0]         time_left_now, time_left_next;
  logic               time_zero;

  sec_countdown #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC),
    .LEVEL_TIME_SEC(LEVEL_TIME_SEC)
  ) u_timer (
    .clk             (clk),
    .resetN          (resetN),
    .load_i          (state_q == START_ST),
    .enable_i        (state_q == PLAY_ST),
    .start_of_frame_i(start_of_frame),
    .time_left_o     (time_left_now),
    .time_left_next_o(time_left_next),
    .zero_o          (time_zero)
  );

  // Loot bookkeeping for the current PLAY cycle; unknown nonzero codes still count.
  always_comb begin
    loot_val = '0;
    case (caught_loot_type)
      LOOT_GOLD: loot_val = SCORE_W'(GOLD_VALUE);
      LOOT_ROCK: loot_val = SCORE_W'(ROCK_VALUE);
      default:   loot_val = '0;
    endcase
    caught_cnt_d  = caught_cnt_q + ((caught_loot_type != LOOT_NONE) ? 8'd1 : 8'd0);
    score_play_d  = sat_add16(score_q, loot_val);
    bonus_val     = SCORE_W'(time_left_next) * SCORE_W'(BONUS_PER_SEC);
    score_clear_d = sat_add16(score_play_d, bonus_val);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q        <= IDLE_ST;
      start_level_q  <= 1'b0;
      level_num_q    <= 3'd0;
      score_q        <= '0;
      level_active_q <= 1'b0;
      game_over_q    <= 1'b0;
      game_won_q     <= 1'b0;
      caught_cnt_q   <= 8'd0;
      target_q       <= 8'd0;
      wait_cnt_q     <= 16'd0;
    end else begin
      start_level_q <= 1'b0;
      case (state_q)
        IDLE_ST, OVER_ST, WON_ST: begin
          if (start_game) begin
            state_q       <= START_ST;
            start_level_q <= 1'b1;
            level_num_q   <= 3'd1;
            score_q       <= '0;
            game_over_q   <= 1'b0;
            game_won_q    <= 1'b0;
          end
        end
        START_ST: begin
          caught_cnt_q <= 8'd0;
          wait_cnt_q   <= 16'd0;
          state_q      <= GEN_ST;
        end
        GEN_ST: begin
          wait_cnt_q <= wait_cnt_q + 16'd1;
          if (wait_cnt_q == GEN_LAST) begin
            target_q       <= total_amount;
            state_q        <= PLAY_ST;
            level_active_q <= 1'b1;
          end
        end
        PLAY_ST: begin
          caught_cnt_q <= caught_cnt_d;
          score_q      <= score_play_d;
          // Clear takes priority over a timeout landing on the same cycle.
          if (caught_cnt_d == target_q) begin
            state_q        <= CLEAR_ST;
            level_active_q <= 1'b0;
            wait_cnt_q     <= 16'd0;
            score_q        <= score_clear_d;
          end else if (time_zero) begin
            state_q        <= OVER_ST;
            level_active_q <= 1'b0;
            game_over_q    <= 1'b1;
          end
        end
        CLEAR_ST: begin
          if (start_of_frame) begin
            if (wait_cnt_q == HOLD_LAST) begin
              if (level_num_q == 3'(NUM_LEVELS)) begin
                state_q    <= WON_ST;
                game_won_q <= 1'b1;
              end else begin
                state_q       <= START_ST;
                start_level_q <= 1'b1;
                level_num_q   <= level_num_q + 3'd1;
              end
            end else begin
              wait_cnt_q <= wait_cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= IDLE_ST;
      endcase
    end
  end

  assign start_level  = start_level_q;
  assign level_num    = level_num_q;
  assign score        = score_q;
  assign time_left    = time_left_now;
  assign level_active = level_active_q;
  assign game_over    = game_over_q;
  assign game_won     = game_won_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: one default instance plus one with a huge
// rock value that drives the score into saturation under the same stimulus.
module tb_level_sequencer;

`ifdef LEVEL_SEQ_TIME_BONUS_EN
  localparam int BONUS = 5;
`else
  localparam int BONUS = 0;
`endif

  logic        clk = 1'b0;
  logic        resetN, start_game, start_of_frame;
  logic [2:0]  caught_loot_type;
  logic [7:0]  total_amount;

  logic        start_level, level_active, game_over, game_won;
  logic [2:0]  level_num;
  logic [15:0] score;
  logic [7:0]  time_left;

  logic        sat_start_level, sat_level_active, sat_game_over, sat_game_won;
  logic [2:0]  sat_level_num;
  logic [15:0] sat_score;
  logic [7:0]  sat_time_left;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_score = 0;
  int gen_n;

  always #5 clk = ~clk;

  level_sequencer u_dut (
    .clk(clk), .resetN(resetN), .start_game(start_game), .start_of_frame(start_of_frame),
    .caught_loot_type(caught_loot_type), .total_amount(total_amount),
    .start_level(start_level), .level_num(level_num), .score(score), .time_left(time_left),
    .level_active(level_active), .game_over(game_over), .game_won(game_won)
  );

  level_sequencer #(.ROCK_VALUE(65519)) u_sat (
    .clk(clk), .resetN(resetN), .start_game(start_game), .start_of_frame(start_of_frame),
    .caught_loot_type(caught_loot_type), .total_amount(total_amount),
    .start_level(sat_start_level), .level_num(sat_level_num), .score(sat_score),
    .time_left(sat_time_left), .level_active(sat_level_active), .game_over(sat_game_over),
    .game_won(sat_game_won)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("  ok %s = %0h", tag, got);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sof();
    start_of_frame = 1'b1;
    tick();
    start_of_frame = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_sof();
      tick();
    end
  endtask

  task automatic wait_play();
    int n;
    n = 0;
    while (!level_active && n < 1000) begin
      tick();
      n++;
    end
    chk("reach_play", 32'(level_active), 32'd1);
  endtask

  task automatic catch_one(input logic [2:0] t);
    caught_loot_type = t;
    tick();
    caught_loot_type = 3'd0;
  endtask

  initial begin
    resetN = 1'b0; start_game = 1'b0; start_of_frame = 1'b0;
    caught_loot_type = 3'd0; total_amount = 8'd3;
    repeat (3) tick();
    chk("rst_level_num", 32'(level_num), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_time_left", 32'(time_left), 32'd0);
    chk("rst_flags", 32'({start_level, level_active, game_over, game_won}), 32'd0);
    resetN = 1'b1;
    tick();

    // Level 1: start pulse, generation wait with ignored catches/frames.
    start_game = 1'b1; tick(); start_game = 1'b0;
    chk("start_pulse", 32'(start_level), 32'd1);
    chk("lvl1_num", 32'(level_num), 32'd1);
    tick();
    chk("pulse_1cyc", 32'(start_level), 32'd0);
    chk("time_load", 32'(time_left), 32'd60);
    gen_n = 1;
    caught_loot_type = 3'd1; start_of_frame = 1'b1;
    repeat (10) begin tick(); gen_n++; end
    caught_loot_type = 3'd0; start_of_frame = 1'b0;
    chk("gen_ign_score", 32'(score), 32'd0);
    chk("gen_ign_time", 32'(time_left), 32'd60);
    while (!level_active && gen_n < 1000) begin
      tick();
      if (!level_active) gen_n++;
    end
    chk("gen_cycles", 32'(gen_n), 32'd512);
    chk("play_entry", 32'(level_active), 32'd1);

    // Catches 1, 2, 1 against a target of 3.
    catch_one(3'd1);
    chk("score_gold", 32'(score), 32'd10);
    tick();
    chk("score_idle", 32'(score), 32'd10);
    catch_one(3'd2);
    chk("score_rock", 32'(score), 32'd11);
    chk("sat_near", 32'(sat_score), 32'hFFF9);
    chk("still_play", 32'(level_active), 32'd1);
    catch_one(3'd1);
    exp_score = 21 + 60 * BONUS;
    chk("score_clear", 32'(score), 32'(exp_score));
    chk("clear_inactive", 32'(level_active), 32'd0);
    chk("sat_score", 32'(sat_score), 32'hFFFF);
    chk("sat_outputs", 32'({sat_start_level, sat_level_num, sat_time_left, sat_level_active,
                            sat_game_over, sat_game_won}), 32'({1'b0, 3'd1, 8'd60, 3'b000}));
    frames(119);
    chk("hold_lvl", 32'({start_level, level_num}), 32'({1'b0, 3'd1}));
    pulse_sof();
    chk("lvl2_pulse", 32'({start_level, level_num}), 32'({1'b1, 3'd2}));

    // Level 2: no catches, timer runs out.
    total_amount = 8'd5;
    wait_play();
    frames(60);
    chk("time_59", 32'(time_left), 32'd59);
    frames(3539);
    chk("time_1", 32'({time_left, game_over}), 32'({8'd1, 1'b0}));
    pulse_sof();
    chk("timeout_over", 32'({game_over, level_active}), 32'({1'b1, 1'b0}));
    chk("timeout_time", 32'(time_left), 32'd0);
    chk("timeout_score", 32'(score), 32'(exp_score));
    tick();
    start_game = 1'b1; tick(); start_game = 1'b0;
    chk("restart", 32'({start_level, level_num, game_over}), 32'({1'b1, 3'd1, 1'b0}));
    chk("restart_score", 32'(score), 32'd0);

    // Level 1 again: last catch lands on the cycle time_left hits 0.
    total_amount = 8'd2;
    wait_play();
    catch_one(3'd1);
    frames(3599);
    chk("coinc_time_1", 32'(time_left), 32'd1);
    caught_loot_type = 3'd2;
    pulse_sof();
    caught_loot_type = 3'd0;
    chk("coinc_clear", 32'({level_active, game_over, time_left}), 32'({1'b0, 1'b0, 8'd0}));
    exp_score = 11;
    chk("coinc_score", 32'(score), 32'(exp_score));
    frames(119);
    pulse_sof();
    chk("lvl2_again", 32'({start_level, level_num}), 32'({1'b1, 3'd2}));

    // Level 2: start_game ignored mid-level, unknown loot code counts for 0.
    total_amount = 8'd1;
    tick();
    start_game = 1'b1; tick(); start_game = 1'b0;
    chk("ign_start", 32'({start_level, level_num}), 32'({1'b0, 3'd2}));
    wait_play();
    catch_one(3'd3);
    exp_score = exp_score + 60 * BONUS;
    chk("odd_loot", 32'({level_active, score}), 32'({1'b0, 16'(exp_score)}));
    frames(119);
    pulse_sof();
    chk("lvl3_pulse", 32'(level_num), 32'd3);

    // Level 3: zero target clears on the first PLAY cycle.
    total_amount = 8'd0;
    wait_play();
    tick();
    exp_score = exp_score + 60 * BONUS;
    chk("zero_target", 32'({level_active, score}), 32'({1'b0, 16'(exp_score)}));
    frames(119);
    pulse_sof();
    chk("lvl4_pulse", 32'(level_num), 32'd4);

    // Level 4: final clear leads to WON.
    total_amount = 8'd1;
    wait_play();
    catch_one(3'd1);
    exp_score = exp_score + 10 + 60 * BONUS;
    chk("lvl4_score", 32'(score), 32'(exp_score));
    frames(119);
    pulse_sof();
    chk("won", 32'({game_won, start_level, level_num}), 32'({1'b1, 1'b0, 3'd4}));
    frames(5);
    chk("won_hold", 32'({game_won, start_level, level_num}), 32'({1'b1, 1'b0, 3'd4}));
    start_game = 1'b1; tick(); start_game = 1'b0;
    chk("won_restart", 32'({start_level, level_num, game_won}), 32'({1'b1, 3'd1, 1'b0}));
    chk("won_restart_score", 32'(score), 32'd0);

    // Reset in the middle of a level.
    tick();
    resetN = 1'b0; tick(); resetN = 1'b1;
    chk("mid_reset", 32'({level_num, time_left, start_level}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
